// File: rtl/registered_accumulator_nir_if.sv
// Stream interface for registered_accumulator_nir: control, sample input and frame result.
// With ACC_SATURATE_EN defined, the clamp flag 'saturated' is carried as well.
interface registered_accumulator_nir_if #(
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 15,
   parameter int CNT_W     = 3
);
   logic                        enable;
   logic                        clear;
   logic                        inReady;
   logic signed [IN_WIDTH-1:0]  in;
   logic signed [OUT_WIDTH-1:0] out;
   logic                        outReady;
   logic                        earlyOutReady;
   logic [CNT_W-1:0]            count;
`ifdef ACC_SATURATE_EN
   logic                        saturated;
`endif

   modport slave (
      input  enable, clear, inReady, in,
      output out, outReady, earlyOutReady, count
`ifdef ACC_SATURATE_EN
      , output saturated
`endif
   );

   modport master (
      output enable, clear, inReady, in,
      input  out, outReady, earlyOutReady, count
`ifdef ACC_SATURATE_EN
      , input saturated
`endif
   );
endinterface

// File: rtl/registered_accumulator_nir.sv
// Frame accumulator: sums ACC_LEN valid signed samples and emits the total with a one-cycle outReady.
// Optional macro ACC_SATURATE_EN clamps the total to OUT_WIDTH and adds the 'saturated' flag.
module registered_accumulator_nir #(
   parameter int IN_WIDTH  = 12,
   parameter int ACC_LEN   = 8,
   parameter int OUT_WIDTH = IN_WIDTH + $clog2(ACC_LEN)
) (
   input  logic                          clk,
   input  logic                          reset,
   registered_accumulator_nir_if.slave   bus
);
   localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int ACC_W = IN_WIDTH + CNT_W;
   localparam int EXT_W = (OUT_WIDTH > ACC_W) ? OUT_WIDTH : ACC_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic signed [OUT_WIDTH-1:0] out_q, out_d;
   logic                        out_ready_q, out_ready_d;
`ifdef ACC_SATURATE_EN
   logic                        sat_q, sat_d;
   logic [EXT_W-OUT_WIDTH:0]    upper;
   logic                        clamp;
`endif

   logic                        first;
   logic [CNT_W-1:0]            eff_cnt;
   logic signed [ACC_W-1:0]     sum;
   logic signed [EXT_W-1:0]     sum_ext;
   logic signed [OUT_WIDTH-1:0] result;

   always_comb begin
      // A clear makes this cycle's sample behave as sample 0 of a fresh frame.
      first   = bus.clear || (count_q == '0);
      eff_cnt = bus.clear ? '0 : count_q;
      sum     = (first ? '0 : acc_q) + ACC_W'(bus.in);
      sum_ext = EXT_W'(sum);
`ifdef ACC_SATURATE_EN
      upper   = sum_ext[EXT_W-1:OUT_WIDTH-1];
      clamp   = !((&upper) || !(|upper));
      if (clamp)
         result = sum_ext[EXT_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else
         result = OUT_WIDTH'(sum_ext);
`else
      result  = OUT_WIDTH'(sum_ext);
`endif
   end

   always_comb begin
      acc_d       = acc_q;
      count_d     = count_q;
      out_d       = out_q;
      out_ready_d = out_ready_q;
`ifdef ACC_SATURATE_EN
      sat_d       = sat_q;
`endif
      if (bus.enable) begin
         out_ready_d = 1'b0;
         if (bus.inReady) begin
            if (eff_cnt == LAST) begin
               out_d       = result;
               out_ready_d = 1'b1;
               count_d     = '0;
`ifdef ACC_SATURATE_EN
               sat_d       = clamp;
`endif
            end else begin
               acc_d   = sum;
               count_d = eff_cnt + 1'b1;
            end
         end else if (bus.clear) begin
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q       <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_ready_q <= 1'b0;
`ifdef ACC_SATURATE_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         acc_q       <= acc_d;
         count_q     <= count_d;
         out_q       <= out_d;
         out_ready_q <= out_ready_d;
`ifdef ACC_SATURATE_EN
         sat_q       <= sat_d;
`endif
      end
   end

   assign bus.out           = out_q;
   assign bus.outReady      = out_ready_q;
   assign bus.count         = count_q;
   assign bus.earlyOutReady = bus.enable & bus.inReady & (count_q == LAST) & ~bus.clear;
`ifdef ACC_SATURATE_EN
   assign bus.saturated     = sat_q;
`endif
endmodule

// File: tb/tb_registered_accumulator_nir.sv
// Scoreboard bench: one exact-width DUT and one 12-bit-output DUT share the same stimulus.
module tb_registered_accumulator_nir;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   q[$];
   int   q12[$];
   int   qs12[$];
   int   pulse_t[$];

   registered_accumulator_nir_if #(.IN_WIDTH(12), .OUT_WIDTH(15), .CNT_W(3)) bus ();
   registered_accumulator_nir_if #(.IN_WIDTH(12), .OUT_WIDTH(12), .CNT_W(3)) bus12 ();

   registered_accumulator_nir #(.IN_WIDTH(12), .ACC_LEN(8)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   registered_accumulator_nir #(.IN_WIDTH(12), .ACC_LEN(8), .OUT_WIDTH(12)) dut12 (
      .clk(clk), .reset(reset), .bus(bus12.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference for the 12-bit-output instance derived from the exact total.
   function automatic int m12(input int s);
`ifdef ACC_SATURATE_EN
      if (s > 2047) return 2047;
      if (s < -2048) return -2048;
      return s;
`else
      logic [11:0] t;
      t = s[11:0];
      return int'($signed(t));
`endif
   endfunction

   function automatic int s12(input int s);
      return ((s > 2047) || (s < -2048)) ? 1 : 0;
   endfunction

   task automatic push(input int exp);
      q.push_back(exp);
      q12.push_back(m12(exp));
      qs12.push_back(s12(exp));
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (bus.outReady) begin
            pulse_t.push_back(cyc);
            if (q.size() == 0) chk("unexpected pulse", 1, 0);
            else chk("out", int'(bus.out), q.pop_front());
`ifdef ACC_SATURATE_EN
            chk("saturated exact", int'(bus.saturated), 0);
`endif
         end
         if (bus12.outReady) begin
            if (q12.size() == 0) chk("unexpected pulse12", 1, 0);
            else begin
               chk("out12", int'(bus12.out), q12.pop_front());
`ifdef ACC_SATURATE_EN
               chk("saturated12", int'(bus12.saturated), qs12.pop_front());
`else
               void'(qs12.pop_front());
`endif
            end
         end
      end
   end

   task automatic drv(input bit en, input bit clr, input bit rdy, input int v,
                      input int exp_cnt, input int exp_early);
      bus.enable = en;    bus12.enable = en;
      bus.clear = clr;    bus12.clear = clr;
      bus.inReady = rdy;  bus12.inReady = rdy;
      bus.in = 12'(v);    bus12.in = 12'(v);
      @(negedge clk);
      if (exp_cnt >= 0) chk("count", int'(bus.count), exp_cnt);
      if (exp_early >= 0) chk("earlyOutReady", int'(bus.earlyOutReady), exp_early);
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int v, input int start);
      for (int i = 0; i < n; i++) drv(1, 0, 1, v, (start + i) % 8, -1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1, 0, 0, 0, -1, -1);
   endtask

   initial begin
      int np;
      bus.enable = 0; bus.clear = 0; bus.inReady = 0; bus.in = '0;
      bus12.enable = 0; bus12.clear = 0; bus12.inReady = 0; bus12.in = '0;
      @(posedge clk); #1;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         bus.enable = 1'($urandom);  bus12.enable = bus.enable;
         bus.clear = 1'($urandom);   bus12.clear = bus.clear;
         bus.inReady = 1'($urandom); bus12.inReady = bus.inReady;
         bus.in = 12'($urandom);     bus12.in = bus.in;
         @(negedge clk);
         chk("reset out", int'(bus.out), 0);
         chk("reset outReady", int'(bus.outReady), 0);
         chk("reset count", int'(bus.count), 0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 55, 0, 0);
         chk("post-reset out", int'(bus.out), 0);
         chk("post-reset outReady", int'(bus.outReady), 0);
      end

      // Basic frame 1..8 with earlyOutReady on the last sample
      push(36);
      for (int i = 1; i <= 8; i++) drv(1, 0, 1, i, i - 1, (i == 8) ? 1 : 0);
      idle(2);
      chk("outReady single pulse", int'(bus.outReady), 0);
      chk("out holds", int'(bus.out), 36);

      // Gaps and a 3-cycle stall with inReady high
      push(36);
      drv(1, 0, 1, 1, 0, -1);
      drv(1, 0, 1, 2, 1, -1);
      drv(1, 0, 0, 77, 2, -1);
      drv(1, 0, 1, 3, 2, -1);
      drv(1, 0, 1, 4, 3, -1);
      for (int i = 0; i < 3; i++) drv(0, 0, 1, 99, 4, 0);
      drv(1, 0, 1, 5, 4, -1);
      drv(1, 0, 0, 0, 5, -1);
      drv(1, 0, 1, 6, 5, -1);
      drv(1, 0, 1, 7, 6, -1);
      drv(1, 0, 1, 8, 7, 1);
      idle(2);

      // Extremes back-to-back
      np = pulse_t.size();
      push(-16384);
      push(16376);
      feed(8, -2048, 0);
      feed(8, 2047, 0);
      idle(2);
      chk("pulse count extremes", pulse_t.size() - np, 2);
      if (pulse_t.size() >= np + 2) chk("pulse spacing", pulse_t[np+1] - pulse_t[np], 8);

      // Clear with a sample aborts the partial frame
      push(14);
      feed(5, 100, 0);
      drv(1, 1, 1, 7, 5, 0);
      feed(7, 1, 1);
      idle(2);

      // Clear without a sample
      feed(2, 3, 0);
      drv(1, 1, 0, 0, 2, -1);
      drv(1, 0, 0, 0, 0, -1);

      // Reset mid-frame
      feed(3, 5, 0);
      reset = 1'b0;
      #1;
      chk("mid reset count", int'(bus.count), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      push(40);
      feed(8, 5, 0);
      idle(2);

      // Values for the 12-bit instance: in-range and overflowing totals
      push(80);
      feed(8, 10, 0);
      push(16376);
      feed(8, 2047, 0);
      idle(3);

      chk("queue drained", q.size(), 0);
      chk("queue12 drained", q12.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
